// File: rtl/operand_sequencer_pkg.sv
// Shared types for the operand sequencer: FSM state encoding and the
// register-block select codes, with the memory-mode classifier.
package operand_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_SRC  = 3'd1,
        ST_READ_DST  = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITE_MEM = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [2:0] SELECT_PC     = 3'd0;
    localparam logic [2:0] SELECT_MEM_R1 = 3'd1;
    localparam logic [2:0] SELECT_MEM_R2 = 3'd2;
    localparam logic [2:0] SELECT_MEM_R3 = 3'd3;
    localparam logic [2:0] SELECT_IMM    = 3'd4;
    localparam logic [2:0] SELECT_R1     = 3'd5;
    localparam logic [2:0] SELECT_R2     = 3'd6;
    localparam logic [2:0] SELECT_R3     = 3'd7;

    // Memory-mode selects address memory indirectly through r1-r3.
    function automatic logic is_mem_select(input logic [2:0] select);
        return (select >= SELECT_MEM_R1) && (select <= SELECT_MEM_R3);
    endfunction

endpackage

// File: rtl/operand_sequencer.sv
// Fetches memory operands, presents both operands to the ALU and retires
// the result to memory or back to the register block. One instruction in flight.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       source_select,
    input  logic [2:0]       destination_select,
    input  logic [WIDTH-1:0] source_address,
    input  logic [WIDTH-1:0] destination_address,
    input  logic             store,
    output logic             busy,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic [WIDTH-1:0] source_value,
    output logic [WIDTH-1:0] destination_value,
    output logic             operands_valid,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] result,
    output logic             store_value,
    output logic [WIDTH-1:0] destination_write,
    output logic             done,
    output logic             bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t           state;
    logic             dst_is_mem;
    logic [WIDTH-1:0] dst_address;
    logic             store_latch;
    logic [WIDTH-1:0] result_latch;
    logic [CNT_W-1:0] wait_count;
    logic             timeout_hit;

    assign timeout_hit       = (TIMEOUT_CYCLES != 0) && (wait_count == CNT_W'(TIMEOUT_CYCLES));
    assign busy              = (state != ST_IDLE);
    assign mem_write_data    = mem_write   ? result_latch : '0;
    assign destination_write = store_value ? result_latch : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            dst_is_mem        <= 1'b0;
            dst_address       <= '0;
            store_latch       <= 1'b0;
            result_latch      <= '0;
            wait_count        <= '0;
            mem_address       <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            source_value      <= '0;
            destination_value <= '0;
            operands_valid    <= 1'b0;
            store_value       <= 1'b0;
            done              <= 1'b0;
            bus_error         <= 1'b0;
        end else begin
            done        <= 1'b0;
            bus_error   <= 1'b0;
            store_value <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dst_is_mem  <= is_mem_select(destination_select);
                        dst_address <= destination_address;
                        store_latch <= store;
                        wait_count  <= '0;
                        if (!is_mem_select(source_select))
                            source_value <= source_address;
                        if (!is_mem_select(destination_select))
                            destination_value <= destination_address;
                        if (is_mem_select(source_select)) begin
                            state       <= ST_READ_SRC;
                            mem_read    <= 1'b1;
                            mem_address <= source_address;
                        end else if (is_mem_select(destination_select)) begin
                            state       <= ST_READ_DST;
                            mem_read    <= 1'b1;
                            mem_address <= destination_address;
                        end else begin
                            state          <= ST_EXECUTE;
                            operands_valid <= 1'b1;
                        end
                    end
                end
                ST_READ_SRC: begin
                    if (mem_ready) begin
                        source_value <= mem_read_data;
                        wait_count   <= '0;
                        if (dst_is_mem) begin
                            state       <= ST_READ_DST;
                            mem_address <= dst_address;
                        end else begin
                            state          <= ST_EXECUTE;
                            mem_read       <= 1'b0;
                            operands_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state     <= ST_DONE;
                        mem_read  <= 1'b0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                ST_READ_DST: begin
                    if (mem_ready) begin
                        destination_value <= mem_read_data;
                        state             <= ST_EXECUTE;
                        mem_read          <= 1'b0;
                        operands_valid    <= 1'b1;
                    end else if (timeout_hit) begin
                        state     <= ST_DONE;
                        mem_read  <= 1'b0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (result_valid) begin
                        result_latch   <= result;
                        operands_valid <= 1'b0;
                        if (store_latch && dst_is_mem) begin
                            state       <= ST_WRITE_MEM;
                            mem_write   <= 1'b1;
                            mem_address <= dst_address;
                            wait_count  <= '0;
                        end else begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            store_value <= store_latch && !dst_is_mem;
                        end
                    end
                end
                ST_WRITE_MEM: begin
                    if (mem_ready) begin
                        state     <= ST_DONE;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                    end else if (timeout_hit) begin
                        state     <= ST_DONE;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                        bus_error <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: register and memory operand paths,
// timeout abort, limit-cycle ready, reset mid-write and back-to-back issue.
module tb_operand_sequencer;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset, start, store, mem_ready, result_valid;
    logic [2:0]   source_select, destination_select;
    logic [W-1:0] source_address, destination_address, mem_read_data, result;
    logic         busy, mem_read, mem_write, operands_valid, store_value, done, bus_error;
    logic [W-1:0] mem_address, mem_write_data, source_value, destination_value, destination_write;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .start(start),
        .source_select(source_select), .destination_select(destination_select),
        .source_address(source_address), .destination_address(destination_address),
        .store(store), .busy(busy), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data), .mem_ready(mem_ready),
        .mem_read_data(mem_read_data), .source_value(source_value),
        .destination_value(destination_value), .operands_valid(operands_valid),
        .result_valid(result_valid), .result(result), .store_value(store_value),
        .destination_write(destination_write), .done(done), .bus_error(bus_error)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] ss, input logic [W-1:0] sa,
                         input logic [2:0] ds, input logic [W-1:0] da, input logic st);
        start = 1'b1; source_select = ss; source_address = sa;
        destination_select = ds; destination_address = da; store = st;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; store = 1'b0; mem_ready = 1'b0; result_valid = 1'b0;
        source_select = '0; destination_select = '0; source_address = '0;
        destination_address = '0; mem_read_data = '0; result = '0;
        step(); step();
        reset = 1'b0;
        checks++; if ({busy, mem_read, mem_write, operands_valid, store_value, done, bus_error} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000", {busy, mem_read, mem_write, operands_valid, store_value, done, bus_error}); end
        checks++; if ({mem_address, mem_write_data, source_value, destination_value, destination_write} !== '0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {mem_address, mem_write_data, source_value, destination_value, destination_write}); end
    endtask

    task automatic test_reg_reg();
        result_valid = 1'b1; result = 16'h0046;
        issue(3'd5, 16'h0012, 3'd6, 16'h0034, 1'b1);
        checks++; if ({busy, operands_valid, mem_read, mem_write} !== 4'b1100) begin
            failures++; $display("FAIL rr_exec_ctrl got=%b exp=1100", {busy, operands_valid, mem_read, mem_write}); end
        checks++; if (source_value !== 16'h0012 || destination_value !== 16'h0034) begin
            failures++; $display("FAIL rr_operands got=%h/%h exp=0012/0034", source_value, destination_value); end
        step();
        result_valid = 1'b0;
        checks++; if ({done, store_value, bus_error, mem_read, mem_write} !== 5'b11000) begin
            failures++; $display("FAIL rr_done_ctrl got=%b exp=11000", {done, store_value, bus_error, mem_read, mem_write}); end
        checks++; if (destination_write !== 16'h0046) begin
            failures++; $display("FAIL rr_dest_write got=%h exp=0046", destination_write); end
        step();
        checks++; if ({busy, done, store_value} !== 3'b000) begin
            failures++; $display("FAIL rr_idle got=%b exp=000", {busy, done, store_value}); end
    endtask

    task automatic test_mem_mem();
        issue(3'd1, 16'h0100, 3'd2, 16'h0200, 1'b1);
        checks++; if (mem_read !== 1'b1 || mem_address !== 16'h0100 || mem_write !== 1'b0) begin
            failures++; $display("FAIL mm_read_src got=%b/%h exp=1/0100", mem_read, mem_address); end
        step();
        checks++; if (mem_read !== 1'b1 || mem_address !== 16'h0100) begin
            failures++; $display("FAIL mm_hold_src got=%b/%h exp=1/0100", mem_read, mem_address); end
        mem_ready = 1'b1; mem_read_data = 16'hAAAA;
        step();
        mem_ready = 1'b0;
        checks++; if (mem_read !== 1'b1 || mem_address !== 16'h0200) begin
            failures++; $display("FAIL mm_read_dst got=%b/%h exp=1/0200", mem_read, mem_address); end
        step();
        mem_ready = 1'b1; mem_read_data = 16'h5555;
        step();
        mem_ready = 1'b0;
        checks++; if (operands_valid !== 1'b1 || mem_read !== 1'b0 || source_value !== 16'hAAAA || destination_value !== 16'h5555) begin
            failures++; $display("FAIL mm_exec got=%b%b %h/%h exp=10 AAAA/5555", operands_valid, mem_read, source_value, destination_value); end
        result_valid = 1'b1; result = 16'hFFFF;
        step();
        result_valid = 1'b0;
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h0200 || mem_write_data !== 16'hFFFF) begin
            failures++; $display("FAIL mm_write got=%b%b %h/%h exp=10 0200/FFFF", mem_write, mem_read, mem_address, mem_write_data); end
        step();
        checks++; if (mem_write !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL mm_write_hold got=%b%b exp=10", mem_write, done); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++; if ({done, store_value, bus_error, mem_write} !== 4'b1000) begin
            failures++; $display("FAIL mm_done got=%b exp=1000", {done, store_value, bus_error, mem_write}); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin
            failures++; $display("FAIL mm_single_done got=%b exp=00", {done, busy}); end
    endtask

    task automatic test_no_store();
        issue(3'd5, 16'h0007, 3'd1, 16'h0300, 1'b0);
        checks++; if (mem_read !== 1'b1 || mem_address !== 16'h0300) begin
            failures++; $display("FAIL ns_read_dst got=%b/%h exp=1/0300", mem_read, mem_address); end
        mem_ready = 1'b1; mem_read_data = 16'h1234;
        step();
        mem_ready = 1'b0;
        checks++; if (source_value !== 16'h0007 || destination_value !== 16'h1234) begin
            failures++; $display("FAIL ns_operands got=%h/%h exp=0007/1234", source_value, destination_value); end
        result_valid = 1'b1; result = 16'h9999;
        step();
        result_valid = 1'b0;
        checks++; if ({done, mem_write, store_value, bus_error} !== 4'b1000) begin
            failures++; $display("FAIL ns_done got=%b exp=1000", {done, mem_write, store_value, bus_error}); end
        step();
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        issue(3'd3, 16'h0400, 3'd6, 16'h0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_read !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL to_read_cycle%0d got=%b%b exp=10", i, mem_read, done); end
            step();
        end
        checks++; if ({done, bus_error, store_value, mem_read} !== 4'b1100) begin
            failures++; $display("FAIL to_abort got=%b exp=1100", {done, bus_error, store_value, mem_read}); end
        step();
        checks++; if ({busy, done, bus_error} !== 3'b000) begin
            failures++; $display("FAIL to_idle got=%b exp=000", {busy, done, bus_error}); end
    endtask

    task automatic test_limit_ready();
        mem_ready = 1'b0;
        issue(3'd3, 16'h0410, 3'd6, 16'h0002, 1'b1);
        step(); step(); step(); step();
        mem_ready = 1'b1; mem_read_data = 16'h0BAD;
        step();
        mem_ready = 1'b0;
        checks++; if ({operands_valid, done, bus_error} !== 3'b100 || source_value !== 16'h0BAD) begin
            failures++; $display("FAIL lr_exec got=%b %h exp=100 0BAD", {operands_valid, done, bus_error}, source_value); end
        result_valid = 1'b1; result = 16'h1111;
        step();
        result_valid = 1'b0;
        checks++; if ({done, bus_error, store_value} !== 3'b101 || destination_write !== 16'h1111) begin
            failures++; $display("FAIL lr_done got=%b %h exp=101 1111", {done, bus_error, store_value}, destination_write); end
        step();
    endtask

    task automatic test_reset_in_write();
        issue(3'd5, 16'h0001, 3'd3, 16'h0500, 1'b1);
        mem_ready = 1'b1; mem_read_data = 16'h0002;
        step();
        mem_ready = 1'b0; result_valid = 1'b1; result = 16'h0ABC;
        step();
        result_valid = 1'b0;
        checks++; if (mem_write !== 1'b1 || mem_address !== 16'h0500) begin
            failures++; $display("FAIL rw_write got=%b/%h exp=1/0500", mem_write, mem_address); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({mem_write, busy, done, operands_valid} !== 4'b0000) begin
            failures++; $display("FAIL rw_reset got=%b exp=0000", {mem_write, busy, done, operands_valid}); end
        step();
        checks++; if (done !== 1'b0) begin
            failures++; $display("FAIL rw_no_done got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        result_valid = 1'b1; result = 16'h0000;
        start = 1'b1; source_select = 3'd4; source_address = 16'h0AAA;
        destination_select = 3'd7; destination_address = 16'h0BBB; store = 1'b0;
        step();
        source_address = 16'h0CCC;
        checks++; if (source_value !== 16'h0AAA || destination_value !== 16'h0BBB || busy !== 1'b1) begin
            failures++; $display("FAIL bb_first got=%h/%h exp=0AAA/0BBB", source_value, destination_value); end
        step();
        checks++; if ({busy, done, store_value} !== 3'b110 || source_value !== 16'h0AAA) begin
            failures++; $display("FAIL bb_ignore_busy got=%b %h exp=110 0AAA", {busy, done, store_value}, source_value); end
        step();
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL bb_idle got=%b exp=0", busy); end
        step();
        start = 1'b0;
        checks++; if (operands_valid !== 1'b1 || source_value !== 16'h0CCC) begin
            failures++; $display("FAIL bb_second got=%b %h exp=1 0CCC", operands_valid, source_value); end
        step();
        result_valid = 1'b0;
        checks++; if (done !== 1'b1) begin
            failures++; $display("FAIL bb_second_done got=%b exp=1", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_reg_reg();
        test_mem_mem();
        test_no_store();
        test_timeout();
        test_limit_ready();
        test_reset_in_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
